// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Holds default geometry and the address validity check.
package regfile_pkg;

    localparam int WIDTH_DEF    = 64;
    localparam int DEPTH_DEF    = 32;
    localparam int NUM_RD_DEF   = 2;
    localparam int NUM_WR_DEF   = 2;
    localparam int ZERO_REG_DEF = 31;

    // A register is real storage only if it is in range and not the zero reg.
    function automatic logic addr_valid(
        input int addr,
        input int depth,
        input int zero_reg
    );
        return (addr >= 0) && (addr < depth) && (addr != zero_reg);
    endfunction

endpackage

// File: rtl/regfile_bypass_sel.sv
// Per-read-port forwarding selector: finds the highest write port hitting rd_addr.
// Ports: rd_addr, wr_en/wr_addr/wr_data (all write ports), hit, data.
module regfile_bypass_sel
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int AW       = 5,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF
) (
    input  logic [AW-1:0]           rd_addr,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    output logic                    hit,
    output logic [WIDTH-1:0]        data
);

    logic any;

    // Later ports overwrite earlier ones, so the highest index wins.
    always_comb begin
        any  = 1'b0;
        data = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] == rd_addr) begin
                any  = 1'b1;
                data = wr_data[w*WIDTH +: WIDTH];
            end
        end
    end

    assign hit = any && addr_valid(int'(rd_addr), DEPTH, ZERO_REG);

endmodule

// File: rtl/regfile_reg.sv
// Single storage register with synchronous active-high reset.
// Ports: clk, reset, write_en, d (write data), q (stored value).
module regfile_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (write_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with zero register, write bypass and pending scoreboard.
// Ports: clk, reset, rd_addr/rd_data/rd_pending, wr_en/wr_addr/wr_data, sb_set/sb_addr.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int NUM_WR   = NUM_WR_DEF,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int BYPASS   = 1,
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_pending,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    input  logic                    sb_set,
    input  logic [AW-1:0]           sb_addr
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] commit;
    logic [DEPTH-1:0] pending;
    logic [DEPTH-1:0] pend_nxt;

    for (genvar g = 0; g < DEPTH; g++) begin : g_store
        if (addr_valid(g, DEPTH, ZERO_REG)) begin : g_reg
            logic             we;
            logic [WIDTH-1:0] wd;

            always_comb begin
                we = 1'b0;
                wd = '0;
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_en[w] && wr_addr[w*AW +: AW] == AW'(g)) begin
                        we = 1'b1;
                        wd = wr_data[w*WIDTH +: WIDTH];
                    end
                end
            end

            assign commit[g] = we;

            regfile_reg #(.WIDTH(WIDTH)) u_reg (
                .clk      (clk),
                .reset    (reset),
                .write_en (we),
                .d        (wd),
                .q        (regs[g])
            );
        end else begin : g_zero
            assign commit[g] = 1'b0;
            assign regs[g]   = '0;
        end
    end

    // Clear on retire first, then set: a new producer supersedes the old one.
    always_comb begin
        pend_nxt = pending;
        for (int a = 0; a < DEPTH; a++) begin
            if (commit[a]) begin
                pend_nxt[a] = 1'b0;
            end
            if (sb_set && sb_addr == AW'(a) && addr_valid(a, DEPTH, ZERO_REG)) begin
                pend_nxt[a] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pend_nxt;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] stored;
        logic             pend_bit;
        logic             hit;
        logic             hit_eff;
        logic [WIDTH-1:0] byp;

        assign ra = rd_addr[p*AW +: AW];

        // Out-of-range addresses match nothing and read as zero.
        always_comb begin
            stored   = '0;
            pend_bit = 1'b0;
            for (int a = 0; a < DEPTH; a++) begin
                if (ra == AW'(a)) begin
                    stored   = regs[a];
                    pend_bit = pending[a];
                end
            end
        end

        regfile_bypass_sel #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .NUM_WR   (NUM_WR),
            .DEPTH    (DEPTH),
            .ZERO_REG (ZERO_REG)
        ) u_byp (
            .rd_addr (ra),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .hit     (hit),
            .data    (byp)
        );

        assign hit_eff = (BYPASS != 0) && !reset && hit;

        assign rd_data[p*WIDTH +: WIDTH] = hit_eff ? byp : stored;
        assign rd_pending[p]             = pend_bit && !hit_eff;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and randomised checks of regfile_mp in three configurations.
// Ports: none (top-level bench).
module tb_regfile_mp;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Default geometry, shared stimulus for BYPASS=1 (A) and BYPASS=0 (B)
    logic [9:0]   a_rd_addr;
    logic [127:0] a_rd_data_a, a_rd_data_b;
    logic [1:0]   a_pend_a, a_pend_b;
    logic [1:0]   a_wr_en;
    logic [9:0]   a_wr_addr;
    logic [127:0] a_wr_data;
    logic         a_sb_set;
    logic [4:0]   a_sb_addr;

    // DEPTH=20, NUM_RD=3, NUM_WR=1
    logic [14:0]  c_rd_addr;
    logic [191:0] c_rd_data;
    logic [2:0]   c_pend;
    logic [0:0]   c_wr_en;
    logic [4:0]   c_wr_addr;
    logic [63:0]  c_wr_data;
    logic         c_sb_set;
    logic [4:0]   c_sb_addr;

    regfile_mp #(.BYPASS(1)) dut_a (
        .clk(clk), .reset(reset),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data_a), .rd_pending(a_pend_a),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .sb_set(a_sb_set), .sb_addr(a_sb_addr)
    );

    regfile_mp #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(reset),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data_b), .rd_pending(a_pend_b),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .sb_set(a_sb_set), .sb_addr(a_sb_addr)
    );

    regfile_mp #(.DEPTH(20), .NUM_RD(3), .NUM_WR(1)) dut_c (
        .clk(clk), .reset(reset),
        .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_pending(c_pend),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .sb_set(c_sb_set), .sb_addr(c_sb_addr)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
        a_sb_set = 1'b0; a_sb_addr = '0;
        c_rd_addr = '0; c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0;
        c_sb_set = 1'b0; c_sb_addr = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int port, input logic [4:0] ad, input logic [63:0] d);
        a_wr_en[port] = 1'b1;
        a_wr_addr[port*5 +: 5] = ad;
        a_wr_data[port*64 +: 64] = d;
    endtask

    task automatic rd(input logic [4:0] r0, input logic [4:0] r1);
        a_rd_addr = {r1, r0};
        #1;
    endtask

    logic [63:0] m [20];
    logic        mp [20];

    initial begin
        idle();
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;

        // reset clears data and pending, writes during reset discarded
        wr(0, 5'd5, 64'hDEAD);
        a_sb_set = 1'b1; a_sb_addr = 5'd5;
        cyc();
        idle();
        rd(5'd5, 5'd5);
        chk("pre_reset_data", a_rd_data_a[63:0], 64'hDEAD);
        chk("pre_reset_pend", 64'(a_pend_a[0]), 64'd1);
        reset = 1'b1;
        wr(0, 5'd5, 64'h1111);
        a_sb_set = 1'b1; a_sb_addr = 5'd5;
        rd(5'd5, 5'd5);
        chk("reset_no_bypass", a_rd_data_a[63:0], 64'hDEAD);
        cyc();
        reset = 1'b0;
        idle();
        rd(5'd5, 5'd5);
        chk("reset_data", a_rd_data_a[63:0], 64'h0);
        chk("reset_pend", 64'(a_pend_a[0]), 64'd0);

        // basic write then read on both ports
        wr(0, 5'd3, 64'h1234);
        cyc();
        idle();
        rd(5'd3, 5'd3);
        chk("basic_p0", a_rd_data_a[63:0], 64'h1234);
        chk("basic_p1", a_rd_data_a[127:64], 64'h1234);

        // bypass with port priority
        wr(0, 5'd7, 64'hAA);
        cyc();
        idle();
        wr(0, 5'd7, 64'hBB);
        wr(1, 5'd7, 64'hCC);
        rd(5'd7, 5'd3);
        chk("byp_hit", a_rd_data_a[63:0], 64'hCC);
        chk("byp_other", a_rd_data_a[127:64], 64'h1234);
        chk("nobyp_old", a_rd_data_b[63:0], 64'hAA);
        cyc();
        idle();
        rd(5'd7, 5'd7);
        chk("byp_stored", a_rd_data_a[63:0], 64'hCC);
        chk("nobyp_stored", a_rd_data_b[127:64], 64'hCC);

        // distinct addresses on both ports both commit
        wr(0, 5'd8, 64'h1);
        wr(1, 5'd9, 64'h2);
        cyc();
        idle();
        rd(5'd8, 5'd9);
        chk("dual_wr0", a_rd_data_a[63:0], 64'h1);
        chk("dual_wr1", a_rd_data_a[127:64], 64'h2);

        // zero register
        wr(0, 5'd31, 64'hFFFF);
        a_sb_set = 1'b1; a_sb_addr = 5'd31;
        rd(5'd31, 5'd31);
        chk("zero_same", a_rd_data_a[63:0], 64'h0);
        cyc();
        idle();
        rd(5'd31, 5'd31);
        chk("zero_next", a_rd_data_a[63:0], 64'h0);
        chk("zero_pend", 64'(a_pend_a[1]), 64'd0);

        // scoreboard
        a_sb_set = 1'b1; a_sb_addr = 5'd4;
        cyc();
        idle();
        rd(5'd4, 5'd4);
        chk("sb_set_a", 64'(a_pend_a[0]), 64'd1);
        chk("sb_set_b", 64'(a_pend_b[1]), 64'd1);
        wr(1, 5'd4, 64'h55);
        rd(5'd4, 5'd4);
        chk("sb_wb_mask", 64'(a_pend_a[0]), 64'd0);
        chk("sb_wb_data", a_rd_data_a[63:0], 64'h55);
        chk("sb_wb_nomask", 64'(a_pend_b[0]), 64'd1);
        cyc();
        idle();
        rd(5'd4, 5'd4);
        chk("sb_clr_a", 64'(a_pend_a[0]), 64'd0);
        chk("sb_clr_b", 64'(a_pend_b[0]), 64'd0);
        wr(0, 5'd4, 64'h66);
        a_sb_set = 1'b1; a_sb_addr = 5'd4;
        cyc();
        idle();
        rd(5'd4, 5'd4);
        chk("sb_set_wins", 64'(a_pend_a[0]), 64'd1);
        chk("sb_set_data", a_rd_data_a[63:0], 64'h66);

        // out-of-range address on the small build
        c_wr_en = 1'b1; c_wr_addr = 5'd25; c_wr_data = 64'h77;
        c_sb_set = 1'b1; c_sb_addr = 5'd25;
        c_rd_addr = {5'd0, 5'd25, 5'd25};
        #1;
        chk("oor_byp", c_rd_data[63:0], 64'h0);
        chk("oor_pend", 64'(c_pend[1]), 64'd0);
        cyc();
        idle();
        c_rd_addr = {5'd0, 5'd0, 5'd25};
        #1;
        chk("oor_next", c_rd_data[63:0], 64'h0);
        chk("oor_r0", c_rd_data[127:64], 64'h0);

        // random traffic against a reference model
        for (int i = 0; i < 20; i++) begin
            m[i] = '0;
            mp[i] = 1'b0;
        end
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            c_wr_en = 1'($urandom_range(0, 1));
            c_wr_addr = 5'($urandom_range(0, 31));
            c_wr_data = {$urandom, $urandom};
            c_sb_set = 1'($urandom_range(0, 1));
            c_sb_addr = 5'($urandom_range(0, 31));
            for (int p = 0; p < 3; p++) begin
                c_rd_addr[p*5 +: 5] = (p == 2) ? c_wr_addr : 5'($urandom_range(0, 31));
            end
            #1;
            for (int p = 0; p < 3; p++) begin
                int ad;
                logic hit;
                logic [63:0] ed;
                logic ep;
                ad = int'(c_rd_addr[p*5 +: 5]);
                hit = c_wr_en[0] && (int'(c_wr_addr) == ad) && (ad < 20);
                ed = (ad < 20) ? m[ad] : 64'h0;
                ep = (ad < 20) ? mp[ad] : 1'b0;
                if (hit) begin
                    ed = c_wr_data;
                    ep = 1'b0;
                end
                chk($sformatf("rand_data_p%0d", p), c_rd_data[p*64 +: 64], ed);
                chk($sformatf("rand_pend_p%0d", p), 64'(c_pend[p]), 64'(ep));
            end
            if (c_wr_en[0] && c_wr_addr < 5'd20) begin
                m[c_wr_addr] = c_wr_data;
                mp[c_wr_addr] = 1'b0;
            end
            if (c_sb_set && c_sb_addr < 5'd20) begin
                mp[c_sb_addr] = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
